// File: rtl/serial_subtractor.sv
// Bit-serial handshaked subtractor: computes in_a - in_b one bit per clock, LSB first,
// returning the difference with unsigned borrow and two's-complement overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;
  logic             a0, b0, d_bit, br_nxt, accept, last_bit;

  // Signed overflow only when operand signs differ and the result sign leaves the minuend's.
  function automatic logic ovf_f(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign d_bit    = a0 ^ b0 ^ br;
  assign br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_sh  <= in_a;
      b_sh  <= in_b;
      a_msb <= in_a[WIDTH-1];
      b_msb <= in_b[WIDTH-1];
      br    <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      res  <= {d_bit, res[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  assign out_diff   = res;
  assign out_borrow = br;
  assign out_ovf    = ovf_f(a_msb, b_msb, res[WIDTH-1]);

endmodule
